// File: rtl/ctrl_ramdrv_mc_pkg.sv
// Shared constants, FSM state encoding and helpers for the multi-channel RAM address driver.
package ctrl_ramdrv_mc_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_NCH        = 2;
  localparam int unsigned DEF_TAP_WIDTH  = 10;

  // Channel index width; a single channel still needs one select bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_CH_W = ch_width(DEF_NCH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ctrl_ramdrv_mc_if.sv
// Config, sample-write, convolution-request and RAM-address bus of the address driver.
interface ctrl_ramdrv_mc_if
  import ctrl_ramdrv_mc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned CH_W       = DEF_CH_W,
  parameter int unsigned TAP_WIDTH  = DEF_TAP_WIDTH
);
  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_ch;
  logic [ADDR_WIDTH-1:0] cfg_bptr;
  logic [ADDR_WIDTH-1:0] cfg_lptr;
  logic                  smp_we;
  logic [CH_W-1:0]       smp_ch;
  logic [ADDR_WIDTH-1:0] smp_addr;
  logic                  start;
  logic [CH_W-1:0]       start_ch;
  logic [ADDR_WIDTH-1:0] coef_ptr;
  logic [TAP_WIDTH-1:0]  taps;
  logic                  busy;
  logic                  addr_vld;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [ADDR_WIDTH-1:0] coef_addr;
  logic                  conv_last;
  logic                  conv_pass;

  modport master (
    output cfg_we, cfg_ch, cfg_bptr, cfg_lptr, smp_we, smp_ch,
           start, start_ch, coef_ptr, taps,
    input  smp_addr, busy, addr_vld, data_addr, coef_addr, conv_last, conv_pass
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_bptr, cfg_lptr, smp_we, smp_ch,
           start, start_ch, coef_ptr, taps,
    output smp_addr, busy, addr_vld, data_addr, coef_addr, conv_last, conv_pass
  );
endinterface

// File: rtl/ctrl_ramdrv_mc_chregs.sv
// Per-channel ring segment bounds and write pointers, with two combinational read ports.
module ctrl_ramdrv_mc_chregs #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NCH        = 2,
  parameter int unsigned CH_W       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [ADDR_WIDTH-1:0] cfg_bptr,
  input  logic [ADDR_WIDTH-1:0] cfg_lptr,
  input  logic                  smp_we,
  input  logic [CH_W-1:0]       smp_ch,
  output logic [ADDR_WIDTH-1:0] smp_wp,
  input  logic [CH_W-1:0]       rd_ch,
  output logic                  rd_ok,
  output logic [ADDR_WIDTH-1:0] rd_bptr,
  output logic [ADDR_WIDTH-1:0] rd_lptr,
  output logic [ADDR_WIDTH-1:0] rd_wp
);
  logic [ADDR_WIDTH-1:0] bptr_q [NCH];
  logic [ADDR_WIDTH-1:0] lptr_q [NCH];
  logic [ADDR_WIDTH-1:0] wp_q   [NCH];
  logic                  smp_ok;

  // Out-of-range channel selects never match a register index, so writes to them drop out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        bptr_q[c] <= '0;
        lptr_q[c] <= '0;
        wp_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_we && (cfg_ch == CH_W'(c))) begin
          bptr_q[c] <= cfg_bptr;
          lptr_q[c] <= cfg_lptr;
          wp_q[c]   <= cfg_bptr;
        end else if (smp_we && (smp_ch == CH_W'(c))) begin
          wp_q[c] <= (wp_q[c] == lptr_q[c]) ? bptr_q[c] : wp_q[c] + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign smp_ok  = ({1'b0, smp_ch} < (CH_W+1)'(NCH));
  assign rd_ok   = ({1'b0, rd_ch} < (CH_W+1)'(NCH));
  assign smp_wp  = smp_ok ? wp_q[smp_ch]   : '0;
  assign rd_bptr = rd_ok  ? bptr_q[rd_ch]  : '0;
  assign rd_lptr = rd_ok  ? lptr_q[rd_ch]  : '0;
  assign rd_wp   = rd_ok  ? wp_q[rd_ch]    : '0;
endmodule

// File: rtl/ctrl_ramdrv_mc.sv
// Multi-channel RAM address driver: sample write slots plus newest-to-oldest convolution walk.
module ctrl_ramdrv_mc
  import ctrl_ramdrv_mc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NCH        = DEF_NCH,
  parameter int unsigned TAP_WIDTH  = DEF_TAP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  ctrl_ramdrv_mc_if.slave  bus
);
  localparam int unsigned CH_W = ch_width(NCH);

  state_e                state_q, state_n;
  logic [ADDR_WIDTH-1:0] bptr_q, bptr_n, lptr_q, lptr_n;
  logic [ADDR_WIDTH-1:0] data_q, data_n, coef_q, coef_n;
  logic [TAP_WIDTH-1:0]  cnt_q, cnt_n;
  logic                  vld_q, vld_n, last_q, last_n, pass_q, pass_n, busy_q, busy_n;
  logic                  rd_ok;
  logic [ADDR_WIDTH-1:0] rd_bptr, rd_lptr, rd_wp;

  // One step toward older samples, wrapping from the segment base to its top.
  function automatic logic [ADDR_WIDTH-1:0] ring_dec(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [ADDR_WIDTH-1:0] b,
                                                     input logic [ADDR_WIDTH-1:0] l);
    return (a == b) ? l : a - ADDR_WIDTH'(1);
  endfunction

  ctrl_ramdrv_mc_chregs #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NCH        (NCH),
    .CH_W       (CH_W)
  ) u_chregs (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (bus.cfg_we),
    .cfg_ch   (bus.cfg_ch),
    .cfg_bptr (bus.cfg_bptr),
    .cfg_lptr (bus.cfg_lptr),
    .smp_we   (bus.smp_we),
    .smp_ch   (bus.smp_ch),
    .smp_wp   (bus.smp_addr),
    .rd_ch    (bus.start_ch),
    .rd_ok    (rd_ok),
    .rd_bptr  (rd_bptr),
    .rd_lptr  (rd_lptr),
    .rd_wp    (rd_wp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bptr_q  <= '0;
      lptr_q  <= '0;
      data_q  <= '0;
      coef_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      bptr_q  <= bptr_n;
      lptr_q  <= lptr_n;
      data_q  <= data_n;
      coef_q  <= coef_n;
      cnt_q   <= cnt_n;
      vld_q   <= vld_n;
      last_q  <= last_n;
      pass_q  <= pass_n;
      busy_q  <= busy_n;
    end
  end

  // cnt_q counts beats still to be presented, including the one currently on the bus.
  always_comb begin
    state_n = state_q;
    bptr_n  = bptr_q;
    lptr_n  = lptr_q;
    data_n  = data_q;
    coef_n  = coef_q;
    cnt_n   = cnt_q;
    vld_n   = 1'b0;
    last_n  = 1'b0;
    pass_n  = 1'b0;
    busy_n  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && rd_ok) begin
          state_n = S_CALC;
          bptr_n  = rd_bptr;
          lptr_n  = rd_lptr;
          data_n  = ring_dec(rd_wp, rd_bptr, rd_lptr);
          coef_n  = bus.coef_ptr;
          cnt_n   = (bus.taps == '0) ? TAP_WIDTH'(1) : bus.taps;
          vld_n   = 1'b1;
          last_n  = (cnt_n == TAP_WIDTH'(1));
          busy_n  = 1'b1;
        end
      end
      S_CALC: begin
        busy_n = 1'b1;
        if (cnt_q == TAP_WIDTH'(1)) begin
          state_n = S_DONE;
          pass_n  = 1'b1;
        end else begin
          cnt_n  = cnt_q - TAP_WIDTH'(1);
          data_n = ring_dec(data_q, bptr_q, lptr_q);
          coef_n = coef_q + ADDR_WIDTH'(1);
          vld_n  = 1'b1;
          last_n = (cnt_q == TAP_WIDTH'(2));
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.addr_vld  = vld_q;
  assign bus.data_addr = data_q;
  assign bus.coef_addr = coef_q;
  assign bus.conv_last = last_q;
  assign bus.conv_pass = pass_q;
endmodule

// File: tb/tb_ctrl_ramdrv_mc.sv
// Directed bench for ctrl_ramdrv_mc: config, sample writes, convolution walks, abort and boundaries.
module tb_ctrl_ramdrv_mc;
  import ctrl_ramdrv_mc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ctrl_ramdrv_mc_if bus ();

  ctrl_ramdrv_mc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_bptr = '0;
    bus.cfg_lptr = '0;
    bus.smp_we   = 1'b0;
    bus.smp_ch   = '0;
    bus.start    = 1'b0;
    bus.start_ch = '0;
    bus.coef_ptr = '0;
    bus.taps     = '0;
  endtask

  task automatic cfg(input logic ch, input logic [11:0] b, input logic [11:0] l);
    bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_bptr = b; bus.cfg_lptr = l;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] outs;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    outs = {bus.busy, bus.addr_vld, bus.conv_last, bus.conv_pass, bus.data_addr, bus.coef_addr};
    n_total++;
    if (outs !== 28'h0) $display("FAIL reset_outs got %h exp 0", outs); else n_pass++;
    n_total++;
    if (bus.smp_addr !== 12'h000) $display("FAIL reset_wp got %h exp 000", bus.smp_addr); else n_pass++;
  endtask

  task automatic test_cfg_smp();
    cfg(1'b0, 12'h010, 12'h017);
    bus.smp_ch = 1'b0;
    bus.smp_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (bus.smp_addr !== 12'h010 + 12'(i))
        $display("FAIL smp_addr_%0d got %h exp %h", i, bus.smp_addr, 12'h010 + 12'(i));
      else n_pass++;
      tick();
    end
    bus.smp_we = 1'b0;
    #1;
    n_total++;
    if (bus.smp_addr !== 12'h013) $display("FAIL smp_addr_3 got %h exp 013", bus.smp_addr); else n_pass++;
  endtask

  task automatic test_conv_walk();
    logic [11:0] exp_d [4];
    exp_d = '{12'h012, 12'h011, 12'h010, 12'h017};
    cfg(1'b1, 12'h020, 12'h02F);
    bus.start = 1'b1; bus.start_ch = 1'b0; bus.taps = 10'd4; bus.coef_ptr = 12'h100;
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == 0) begin bus.smp_we = 1'b1; bus.smp_ch = 1'b1; end
      if (b == 1) bus.smp_we = 1'b0;
      #1;
      n_total++;
      if (bus.addr_vld !== 1'b1 || bus.busy !== 1'b1)
        $display("FAIL walk_vld_%0d got vld=%b busy=%b exp 1 1", b, bus.addr_vld, bus.busy);
      else n_pass++;
      n_total++;
      if (bus.data_addr !== exp_d[b] || bus.coef_addr !== 12'h100 + 12'(b))
        $display("FAIL walk_addr_%0d got %h/%h exp %h/%h", b, bus.data_addr, bus.coef_addr,
                 exp_d[b], 12'h100 + 12'(b));
      else n_pass++;
      n_total++;
      if (bus.conv_last !== (b == 3))
        $display("FAIL walk_last_%0d got %b exp %b", b, bus.conv_last, (b == 3));
      else n_pass++;
      tick();
    end
    #1;
    n_total++;
    if ({bus.conv_pass, bus.addr_vld, bus.busy, bus.conv_last} !== 4'b1010 || bus.data_addr !== 12'h017)
      $display("FAIL walk_done got pass=%b vld=%b busy=%b last=%b d=%h exp 1 0 1 0 017",
               bus.conv_pass, bus.addr_vld, bus.busy, bus.conv_last, bus.data_addr);
    else n_pass++;
    tick();
    n_total++;
    if (bus.conv_pass !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL walk_idle got pass=%b busy=%b exp 0 0", bus.conv_pass, bus.busy);
    else n_pass++;
    bus.smp_ch = 1'b0;
    #1;
    n_total++;
    if (bus.smp_addr !== 12'h013) $display("FAIL ch0_wp_kept got %h exp 013", bus.smp_addr); else n_pass++;
    bus.smp_ch = 1'b1;
    #1;
    n_total++;
    if (bus.smp_addr !== 12'h021) $display("FAIL ch1_wp got %h exp 021", bus.smp_addr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1; bus.start_ch = 1'b0; bus.taps = 10'd0; bus.coef_ptr = 12'h200;
    tick();
    #1;
    n_total++;
    if ({bus.addr_vld, bus.conv_last} !== 2'b11 || bus.data_addr !== 12'h012 || bus.coef_addr !== 12'h200)
      $display("FAIL taps0_beat got vld=%b last=%b %h/%h exp 1 1 012/200",
               bus.addr_vld, bus.conv_last, bus.data_addr, bus.coef_addr);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.conv_pass, bus.addr_vld, bus.busy} !== 3'b101)
      $display("FAIL busy_start_ignored got pass=%b vld=%b busy=%b exp 1 0 1",
               bus.conv_pass, bus.addr_vld, bus.busy);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.conv_pass, bus.addr_vld, bus.busy} !== 3'b000)
      $display("FAIL done_start_ignored got pass=%b vld=%b busy=%b exp 0 0 0",
               bus.conv_pass, bus.addr_vld, bus.busy);
    else n_pass++;
    bus.taps = 10'd2; bus.coef_ptr = 12'h210;
    tick();
    bus.start = 1'b0;
    #1;
    n_total++;
    if (bus.addr_vld !== 1'b1 || bus.conv_last !== 1'b0 || bus.coef_addr !== 12'h210 || bus.data_addr !== 12'h012)
      $display("FAIL restart_beat1 got vld=%b last=%b %h/%h exp 1 0 012/210",
               bus.addr_vld, bus.conv_last, bus.data_addr, bus.coef_addr);
    else n_pass++;
    tick();
    n_total++;
    if (bus.addr_vld !== 1'b1 || bus.conv_last !== 1'b1 || bus.coef_addr !== 12'h211 || bus.data_addr !== 12'h011)
      $display("FAIL restart_beat2 got vld=%b last=%b %h/%h exp 1 1 011/211",
               bus.addr_vld, bus.conv_last, bus.data_addr, bus.coef_addr);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_rst_abort();
    logic [27:0] outs;
    logic        saw_pass;
    bus.start = 1'b1; bus.start_ch = 1'b0; bus.taps = 10'd8; bus.coef_ptr = 12'h300;
    tick();
    bus.start = 1'b0;
    tick();
    n_total++;
    if (bus.addr_vld !== 1'b1 || bus.data_addr !== 12'h011 || bus.coef_addr !== 12'h301)
      $display("FAIL abort_beat2 got vld=%b %h/%h exp 1 011/301", bus.addr_vld, bus.data_addr, bus.coef_addr);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.smp_ch = 1'b0;
    #1;
    outs = {bus.busy, bus.addr_vld, bus.conv_last, bus.conv_pass, bus.data_addr, bus.coef_addr};
    n_total++;
    if (outs !== 28'h0) $display("FAIL abort_outs got %h exp 0", outs); else n_pass++;
    n_total++;
    if (bus.smp_addr !== 12'h000) $display("FAIL abort_wp got %h exp 000", bus.smp_addr); else n_pass++;
    saw_pass = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw_pass = saw_pass | bus.conv_pass | bus.addr_vld;
    end
    n_total++;
    if (saw_pass !== 1'b0) $display("FAIL abort_no_pass got %b exp 0", saw_pass); else n_pass++;
  endtask

  task automatic test_boundaries();
    logic [11:0] exp_c;
    cfg(1'b1, 12'h030, 12'h030);
    bus.smp_we = 1'b1; bus.smp_ch = 1'b1;
    tick(); tick();
    bus.smp_we = 1'b0;
    #1;
    n_total++;
    if (bus.smp_addr !== 12'h030) $display("FAIL single_slot_wp got %h exp 030", bus.smp_addr); else n_pass++;
    bus.start = 1'b1; bus.start_ch = 1'b1; bus.taps = 10'd3; bus.coef_ptr = 12'hFFE;
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      exp_c = 12'hFFE + 12'(b);
      #1;
      n_total++;
      if (bus.addr_vld !== 1'b1 || bus.data_addr !== 12'h030 || bus.coef_addr !== exp_c || bus.conv_last !== (b == 2))
        $display("FAIL single_slot_beat_%0d got vld=%b last=%b %h/%h exp 1 %b 030/%h",
                 b, bus.addr_vld, bus.conv_last, bus.data_addr, bus.coef_addr, (b == 2), exp_c);
      else n_pass++;
      tick();
    end
    tick();
    cfg(1'b0, 12'h040, 12'h04F);
    bus.smp_we = 1'b1; bus.smp_ch = 1'b0;
    tick(); tick();
    bus.cfg_we = 1'b1; bus.cfg_ch = 1'b0; bus.cfg_bptr = 12'h050; bus.cfg_lptr = 12'h05F;
    tick();
    bus.cfg_we = 1'b0; bus.smp_we = 1'b0;
    #1;
    n_total++;
    if (bus.smp_addr !== 12'h050) $display("FAIL cfg_wins got %h exp 050", bus.smp_addr); else n_pass++;
    cfg(1'b0, 12'h060, 12'h061);
    bus.smp_we = 1'b1;
    tick(); tick();
    bus.smp_we = 1'b0;
    #1;
    n_total++;
    if (bus.smp_addr !== 12'h060) $display("FAIL wp_wrap got %h exp 060", bus.smp_addr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_cfg_smp();
    test_conv_walk();
    test_back_to_back();
    test_rst_abort();
    test_boundaries();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
